clock_tick_scheduler: RTL and testbench
=======================================

# clock_tick_scheduler

Programmable tick scheduler that replaces fixed, compile-time clock division for timing events. A single shared runtime-programmable prescaler produces a base tick; up to four channel down-counters consume that tick and raise one-cycle expiry strobes and a level interrupt. The block sits on the CPU register bus and gives software the ability to configure, start, stop and acknowledge timers without generating derived clocks. Everything stays in the `clk_in` domain.

## Interface
- `CHANNELS`, 3: number of timer channels, 1..4.
- `clk_in`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `we`  in  1  register write strobe, one cycle per write.
- `addr`  in  3  register address.
- `wdata`  in  16  write data.
- `rdata`  out  16  read data for `addr`, registered, 1-cycle latency.
- `base_tick`  out  1  one-cycle pulse on each prescaler rollover.
- `expire`  out  CHANNELS  per-channel one-cycle expiry strobe.
- `irq`  out  1  OR of all pending bits.

## Operation
- Register map:
  - 0: PRESCALE[15:0], R/W.
  - 1: CTRL, R/W. Bits [3:0] are ENABLE[ch]. Bits [7:4] are PERIODIC[ch]. Bits for channels ≥ CHANNELS read 0 and ignore writes.
  - 2: PENDING[3:0]. Write-1-to-clear.
  - 3: reads 0.
  - 4+ch: RELOAD[ch][15:0], R/W. Addresses for channels ≥ CHANNELS read 0.
- Prescaler:
  - 16-bit up-counter `pcnt`.
  - In a cycle where `pcnt == PRESCALE`, the tick is active, and `pcnt` becomes 0 on the next cycle. Otherwise `pcnt` increments.
  - Base tick period is PRESCALE+1 clocks. PRESCALE=0 gives a tick every cycle.
  - Writing PRESCALE sets `pcnt` to 0 on the next cycle, and suppresses the tick in the write cycle.
- Channel counter `cnt[ch]` (16 bits):
  - A CTRL write that moves ENABLE[ch] from 0 to 1 loads `cnt[ch]` from RELOAD[ch]. The tick in that cycle is ignored for that channel.
  - A CTRL write that clears ENABLE[ch] stops the counter and holds its value.
  - On a tick with ENABLE[ch]=1:
    - If `cnt[ch] != 0`: decrement `cnt[ch]`.
    - If `cnt[ch] == 0`: expiry. PENDING[ch] is set, `expire[ch]` pulses, and the counter is handled by mode:
      - PERIODIC[ch]=1: reload `cnt[ch]` from RELOAD[ch].
      - PERIODIC[ch]=0: clear ENABLE[ch] in hardware (one-shot).
  - Expiry period is (RELOAD+1)×(PRESCALE+1) clocks.
- RELOAD writes while a channel is running take effect at the next reload or enable, not immediately.
- Simultaneous events:
  - Hardware expiry and a W1C of the same PENDING bit in one cycle: the set wins.
  - One-shot hardware clear and a CTRL write in one cycle: the CTRL write wins.
  - Expiries on several channels in one cycle: all are set independently.
- `irq` = |PENDING, registered.
- No backpressure and no handshake: every write completes in one cycle.

## Timing
- Reset (synchronous, any cycle, including mid-count) clears:
  - PRESCALE, CTRL, PENDING, all RELOAD and `cnt` registers, and `pcnt`.
  - Outputs: `rdata`=0, `base_tick`=0, `expire`=0, `irq`=0.
  - Nothing survives reset.
- `base_tick` is registered: high the cycle after the `pcnt == PRESCALE` cycle.
- `expire[ch]` is registered: high the cycle after the expiring tick cycle. PENDING[ch] and `irq` also update in that same cycle.
- Enabling at cycle E with PRESCALE=P, RELOAD=R, and `pcnt` = 0 at E+1:
  - The first tick is at E+1+P.
  - The first `expire` is at E+2+P+R(P+1).
- `rdata` reflects `addr` as sampled in the previous cycle. A write and a read to the same address in one cycle return the old value; the new value is visible one cycle later.
- Counters wrap nowhere. `pcnt` never exceeds PRESCALE, because a PRESCALE write resets it.

## Test plan
- Reset, then PRESCALE=3, RELOAD0=2, CTRL=0x0011 (ch0 enabled, periodic): `expire[0]` pulses every 12 clocks; `base_tick` pulses every 4 clocks; `irq` rises with the first expiry.
- One-shot: PRESCALE=0, RELOAD1=5, CTRL=0x0002: exactly one `expire[1]` pulse 7 cycles after the write; CTRL reads back 0x0000 afterwards; PENDING reads 0x0002.
- Write PENDING=0x0002 in the same cycle as a ch1 periodic expiry: PENDING[1] remains 1 and `irq` stays high. A later W1C clears it and `irq` falls the next cycle.
- Write PRESCALE=9 mid-count: no `base_tick` in the write cycle; the next tick comes exactly 10 cycles later.
- Three channels with RELOAD=0,1,3 and PRESCALE=1, all periodic: expiry periods of 2, 4 and 8 clocks respectively; coincident expiries all set their pending bits.
- Assert `reset` for one cycle while channels are running: the following cycle all outputs are 0, CTRL and PENDING read 0x0000, and there are no further expiries.

Source files
------------

// File: rtl/clock_tick_scheduler.sv
// Programmable tick scheduler: one runtime prescaler produces a base tick that
// drives up to four down-counting timer channels (one-shot or periodic).
module clock_tick_scheduler #(
    parameter int CHANNELS = 3
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                we,
    input  logic [2:0]          addr,
    input  logic [15:0]         wdata,
    output logic [15:0]         rdata,
    output logic                base_tick,
    output logic [CHANNELS-1:0] expire,
    output logic                irq
);
    logic [15:0]               prescale_q, pcnt_q, pcnt_d;
    logic [CHANNELS-1:0]       en_q, en_d, per_q, pend_q, pend_d, exp_d, exp_q;
    logic [CHANNELS-1:0][15:0] reload_q, cnt_q, cnt_d;
    logic [15:0]               rdata_q, rdata_d, ctrl_rd, pend_rd;
    logic                      base_tick_q, irq_q;
    logic                      wr_pre, wr_ctrl, wr_pend, tick;

    assign wr_pre  = we && (addr == 3'd0);
    assign wr_ctrl = we && (addr == 3'd1);
    assign wr_pend = we && (addr == 3'd2);

    // A PRESCALE write restarts the prescaler and swallows the tick in that cycle.
    assign tick   = (pcnt_q == prescale_q) && !wr_pre;
    assign pcnt_d = (wr_pre || pcnt_q == prescale_q) ? 16'd0 : pcnt_q + 16'd1;

    always_comb begin
        en_d  = en_q;
        cnt_d = cnt_q;
        exp_d = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (wr_ctrl && wdata[ch] && !en_q[ch]) begin
                cnt_d[ch] = reload_q[ch];
            end else if (tick && en_q[ch] && !(wr_ctrl && !wdata[ch])) begin
                if (cnt_q[ch] != 16'd0) begin
                    cnt_d[ch] = cnt_q[ch] - 16'd1;
                end else begin
                    exp_d[ch] = 1'b1;
                    if (per_q[ch]) cnt_d[ch] = reload_q[ch];
                    else           en_d[ch]  = 1'b0;
                end
            end
            // Software CTRL writes override the one-shot hardware clear.
            if (wr_ctrl) en_d[ch] = wdata[ch];
        end
        pend_d = (pend_q & ~(wr_pend ? wdata[CHANNELS-1:0] : '0)) | exp_d;
    end

    always_comb begin
        ctrl_rd                  = '0;
        pend_rd                  = '0;
        ctrl_rd[CHANNELS-1:0]    = en_q;
        ctrl_rd[4 +: CHANNELS]   = per_q;
        pend_rd[CHANNELS-1:0]    = pend_q;
        rdata_d                  = '0;
        case (addr)
            3'd0:    rdata_d = prescale_q;
            3'd1:    rdata_d = ctrl_rd;
            3'd2:    rdata_d = pend_rd;
            default: begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    if (addr == 3'(4 + ch)) rdata_d = reload_q[ch];
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            prescale_q  <= '0;
            pcnt_q      <= '0;
            en_q        <= '0;
            per_q       <= '0;
            pend_q      <= '0;
            reload_q    <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            base_tick_q <= 1'b0;
            exp_q       <= '0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_pre)  prescale_q <= wdata;
            if (wr_ctrl) per_q      <= wdata[4 +: CHANNELS];
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (we && addr == 3'(4 + ch)) reload_q[ch] <= wdata;
            end
            pcnt_q      <= pcnt_d;
            en_q        <= en_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            rdata_q     <= rdata_d;
            base_tick_q <= tick;
            exp_q       <= exp_d;
            irq_q       <= |pend_d;
        end
    end

    assign rdata     = rdata_q;
    assign base_tick = base_tick_q;
    assign expire    = exp_q;
    assign irq       = irq_q;
endmodule

// File: tb/tb_clock_tick_scheduler.sv
// Directed bench for clock_tick_scheduler: prescaler, periodic/one-shot
// channels, W1C races, mid-count PRESCALE write and reset behaviour.
module tb_clock_tick_scheduler;
    logic        clk_in = 1'b0;
    logic        reset, we;
    logic [2:0]  addr;
    logic [15:0] wdata, rdata;
    logic        base_tick, irq;
    logic [2:0]  expire;
    int          errors = 0, checks = 0;
    logic [15:0] n, b;
    logic [2:0]  tbl [16];

    clock_tick_scheduler #(.CHANNELS(3)) dut (
        .clk_in(clk_in), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .base_tick(base_tick), .expire(expire), .irq(irq)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        we = 1'b1; addr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        addr = a;
        step();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tbl = '{3'b001, 3'b000, 3'b011, 3'b000, 3'b001, 3'b000, 3'b111, 3'b000,
                3'b001, 3'b000, 3'b011, 3'b000, 3'b001, 3'b000, 3'b111, 3'b000};
        reset = 1'b1; we = 1'b0; addr = 3'd0; wdata = 16'd0;
        step(); step();
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_base_tick", 16'(base_tick), 16'h0);
        chk("rst_expire", 16'(expire), 16'h0);
        chk("rst_irq", 16'(irq), 16'h0);
        reset = 1'b0;
        rd(3'd1); chk("rst_ctrl", rdata, 16'h0);

        // Periodic ch0, PRESCALE=3, RELOAD=2: first expire at E+11, then every 12.
        wr(3'd0, 16'd3); wr(3'd4, 16'd2); wr(3'd1, 16'h0011);
        chk("t1_irq_idle", 16'(irq), 16'h0);
        n = 0; repeat (9) begin step(); n = n + 16'(expire[0]); end
        chk("t1_no_early_exp", n, 16'd0);
        step();
        chk("t1_first_exp", 16'(expire[0]), 16'h1);
        chk("t1_irq_rise", 16'(irq), 16'h1);
        n = 0; b = 0;
        repeat (11) begin step(); n = n + 16'(expire[0]); b = b + 16'(base_tick); end
        chk("t1_gap", n, 16'd0);
        step(); b = b + 16'(base_tick);
        chk("t1_period12", 16'(expire[0]), 16'h1);
        chk("t1_base_ticks", b, 16'd3);
        rd(3'd2); chk("t1_pending", rdata, 16'h0001);
        wr(3'd1, 16'h0000); wr(3'd2, 16'h0001);
        chk("t1_irq_clear", 16'(irq), 16'h0);

        // One-shot ch1, PRESCALE=0, RELOAD=5: single expire 7 cycles after the write.
        wr(3'd0, 16'd0); wr(3'd5, 16'd5); wr(3'd1, 16'h0002);
        n = 0; repeat (5) begin step(); n = n + 16'(expire[1]); end
        chk("t2_no_early_exp", n, 16'd0);
        step();
        chk("t2_exp_at_7", 16'(expire[1]), 16'h1);
        n = 0; repeat (10) begin step(); n = n + 16'(expire[1]); end
        chk("t2_single_pulse", n, 16'd0);
        rd(3'd1); chk("t2_ctrl_cleared", rdata, 16'h0000);
        rd(3'd2); chk("t2_pending", rdata, 16'h0002);
        chk("t2_irq", 16'(irq), 16'h1);

        // W1C of PENDING[1] in the same cycle as a ch1 periodic expiry (period 3).
        wr(3'd2, 16'h0002); wr(3'd5, 16'd2); wr(3'd1, 16'h0022);
        repeat (5) step();
        wr(3'd2, 16'h0002);
        chk("t3_exp_aligned", 16'(expire[1]), 16'h1);
        chk("t3_irq_held", 16'(irq), 16'h1);
        rd(3'd2); chk("t3_set_wins", rdata, 16'h0002);
        wr(3'd1, 16'h0000);
        chk("t3_irq_before_w1c", 16'(irq), 16'h1);
        wr(3'd2, 16'h0002);
        chk("t3_irq_fall", 16'(irq), 16'h0);
        rd(3'd2); chk("t3_pending_clr", rdata, 16'h0000);

        // PRESCALE=9 written in a tick cycle: tick suppressed, next one 10 cycles on.
        wr(3'd0, 16'd3);
        repeat (3) step();
        wr(3'd0, 16'd9);
        chk("t4_suppressed", 16'(base_tick), 16'h0);
        n = 0; repeat (9) begin step(); n = n + 16'(base_tick); end
        chk("t4_no_tick", n, 16'd0);
        step();
        chk("t4_tick_10", 16'(base_tick), 16'h1);

        // Three periodic channels, PRESCALE=1, RELOAD 0/1/3: periods 2/4/8.
        wr(3'd2, 16'h0007); wr(3'd4, 16'd0); wr(3'd5, 16'd1); wr(3'd6, 16'd3);
        wr(3'd0, 16'd1); wr(3'd1, 16'h0077);
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("t5_exp_c%0d", k + 2), 16'(expire), 16'(tbl[k]));
        end
        rd(3'd2); chk("t5_pending_all", rdata, 16'h0007);
        chk("t5_irq", 16'(irq), 16'h1);
        wr(3'd6, 16'h00AB);
        chk("t5_rw_old", rdata, 16'h0003);
        step();
        chk("t5_rw_new", rdata, 16'h00AB);
        rd(3'd7); chk("t5_absent_reload", rdata, 16'h0000);

        // Reset while channels are running.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rdata", rdata, 16'h0);
        chk("t6_base_tick", 16'(base_tick), 16'h0);
        chk("t6_expire", 16'(expire), 16'h0);
        chk("t6_irq", 16'(irq), 16'h0);
        rd(3'd1); chk("t6_ctrl", rdata, 16'h0000);
        rd(3'd2); chk("t6_pending", rdata, 16'h0000);
        n = 0; repeat (20) begin step(); n = n + 16'(|expire); end
        chk("t6_no_expiry", n, 16'd0);
        wr(3'd1, 16'hFFFF);
        rd(3'd1); chk("t6_ctrl_mask", rdata, 16'h0077);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
